bgm_scheduler: RTL

- Sequences the single shared mp3_driver / VS1003 SPI path between background tracks (start, in-game, end) and one-shot sound effects (SFX).
- Chooses which track ROM feeds the driver through `track_sel`.
- Resets the driver cleanly with `drv_rst` on every track switch.
- Loops or stops background music at end of track.
- Lets an SFX preempt background music, then restarts the background track from its beginning.

---
 rtl/bgm_scheduler.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/bgm_scheduler.sv
// rtl/bgm_scheduler.sv - arbiter for the shared mp3_driver path between background music and SFX
//
// Purpose:
//   Owns the single mp3_driver / VS1003 SPI path. Background tracks (bgm_sel)
//   play either in a loop or once, depending on LOOP_MASK. One-shot sound
//   effects (sfx_req/sfx_id) preempt background music, and the background track
//   restarts from its beginning when the effect ends. Every track switch holds
//   the driver in reset (drv_rst) for a fixed window so it always starts from a
//   clean state.
//
// Ports:
//   mp3_clk     in   1  clock, all state on rising edge
//   rst         in   1  asynchronous active-low reset
//   bgm_sel     in   3  requested background track (0 = silence)
//   sfx_req     in   1  one-cycle pulse, play sfx_id once
//   sfx_id      in   3  SFX track id, sampled with sfx_req
//   mute        in   1  level, forces silence while high
//   music_over  in   1  end-of-track pulse from mp3_driver
//   drv_rst     out  1  active-high driver reset / ROM enable gating
//   track_sel   out  3  ROM/data mux select for the driver
//   playing     out  1  driver out of reset and playing
//   sfx_active  out  1  an SFX currently owns the driver

module bgm_scheduler #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [7:0]  LOOP_MASK   = 8'b0000_0110
) (
  input  logic       mp3_clk,
  input  logic       rst,
  input  logic [2:0] bgm_sel,
  input  logic       sfx_req,
  input  logic [2:0] sfx_id,
  input  logic       mute,
  input  logic       music_over,
  output logic       drv_rst,
  output logic [2:0] track_sel,
  output logic       playing,
  output logic       sfx_active
);

  // The counter has to reach HOLD_CYCLES itself, so it needs one extra code.
  localparam int unsigned     CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cur_bgm_q, cur_bgm_d;
  logic             sfx_pend_q, sfx_pend_d;
  logic [2:0]       sfx_pend_id_q, sfx_pend_id_d;
  logic             drv_rst_q, drv_rst_d;
  logic [2:0]       track_sel_q, track_sel_d;
  logic             playing_q, playing_d;
  logic             sfx_active_q, sfx_active_d;

  // Transition requests raised by the per-state logic and applied in one place,
  // so every entry into HOLD or IDLE sets the outputs the same way.
  logic       enter_hold;
  logic       enter_idle;
  logic [2:0] hold_track;
  logic       hold_sfx;
  logic       take_pend;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_bgm_d     = cur_bgm_q;
    drv_rst_d     = drv_rst_q;
    track_sel_d   = track_sel_q;
    playing_d     = playing_q;
    sfx_active_d  = sfx_active_q;
    sfx_pend_d    = sfx_pend_q;
    sfx_pend_id_d = sfx_pend_id_q;
    enter_hold    = 1'b0;
    enter_idle    = 1'b0;
    hold_track    = track_sel_q;
    hold_sfx      = 1'b0;
    take_pend     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mute) begin
          if (sfx_pend_q) begin
            enter_hold = 1'b1;
            hold_track = sfx_pend_id_q;
            hold_sfx   = 1'b1;
            take_pend  = 1'b1;
          end else if (bgm_sel != 3'd0) begin
            enter_hold = 1'b1;
            hold_track = bgm_sel;
            cur_bgm_d  = bgm_sel;
          end
        end
      end

      S_HOLD: begin
        if (mute) begin
          enter_idle = 1'b1;
        end else if (sfx_pend_q) begin
          enter_hold = 1'b1;
          hold_track = sfx_pend_id_q;
          hold_sfx   = 1'b1;
          take_pend  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_PLAY;
          drv_rst_d = 1'b0;
          playing_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PLAY: begin
        if (mute) begin
          enter_idle = 1'b1;
        end else if (sfx_pend_q) begin
          enter_hold = 1'b1;
          hold_track = sfx_pend_id_q;
          hold_sfx   = 1'b1;
          take_pend  = 1'b1;
        end else if (music_over && sfx_active_q) begin
          // SFX finished: resume whatever background track is selected now.
          cur_bgm_d = bgm_sel;
          if (bgm_sel != 3'd0) begin
            enter_hold = 1'b1;
            hold_track = bgm_sel;
          end else begin
            enter_idle = 1'b1;
          end
        end else if (music_over) begin
          if (LOOP_MASK[cur_bgm_q]) begin
            enter_hold = 1'b1;
            hold_track = cur_bgm_q;
          end else begin
            state_d   = S_DONE;
            drv_rst_d = 1'b1;
            playing_d = 1'b0;
          end
        end else if (!sfx_active_q && (bgm_sel != cur_bgm_q)) begin
          cur_bgm_d = bgm_sel;
          if (bgm_sel != 3'd0) begin
            enter_hold = 1'b1;
            hold_track = bgm_sel;
          end else begin
            enter_idle = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (mute) begin
          enter_idle = 1'b1;
        end else if (sfx_pend_q) begin
          enter_hold = 1'b1;
          hold_track = sfx_pend_id_q;
          hold_sfx   = 1'b1;
          take_pend  = 1'b1;
        end else if (bgm_sel != cur_bgm_q) begin
          cur_bgm_d = bgm_sel;
          if (bgm_sel != 3'd0) begin
            enter_hold = 1'b1;
            hold_track = bgm_sel;
          end else begin
            enter_idle = 1'b1;
          end
        end
      end

      default: begin
        enter_idle = 1'b1;
      end
    endcase

    if (enter_hold) begin
      state_d      = S_HOLD;
      cnt_d        = '0;
      drv_rst_d    = 1'b1;
      playing_d    = 1'b0;
      track_sel_d  = hold_track;
      sfx_active_d = hold_sfx;
    end else if (enter_idle) begin
      state_d      = S_IDLE;
      drv_rst_d    = 1'b1;
      playing_d    = 1'b0;
      sfx_active_d = 1'b0;
    end

    // A pending SFX is dropped once consumed or while muted; a fresh request
    // (outside mute) always wins over whatever was pending or just consumed.
    if (take_pend || mute) begin
      sfx_pend_d = 1'b0;
    end
    if (sfx_req && !mute) begin
      sfx_pend_d    = 1'b1;
      sfx_pend_id_d = sfx_id;
    end
  end

  always_ff @(posedge mp3_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_bgm_q     <= 3'd0;
      sfx_pend_q    <= 1'b0;
      sfx_pend_id_q <= 3'd0;
      drv_rst_q     <= 1'b1;
      track_sel_q   <= 3'd0;
      playing_q     <= 1'b0;
      sfx_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_bgm_q     <= cur_bgm_d;
      sfx_pend_q    <= sfx_pend_d;
      sfx_pend_id_q <= sfx_pend_id_d;
      drv_rst_q     <= drv_rst_d;
      track_sel_q   <= track_sel_d;
      playing_q     <= playing_d;
      sfx_active_q  <= sfx_active_d;
    end
  end

  assign drv_rst    = drv_rst_q;
  assign track_sel  = track_sel_q;
  assign playing    = playing_q;
  assign sfx_active = sfx_active_q;

endmodule
